// File: rtl/pc_sequencer_if.sv
// Bundle of PC-control, instruction-fetch and datapath signals between pc_sequencer and its neighbours.
// master = sequencer side, slave = PC / memory / datapath side.
interface pc_sequencer_if;
    logic [15:0] pc_value;
    logic [15:0] pc_in;
    logic        pc_load;
    logic        pc_inc;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] instr;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic [15:0] jump_target;
    logic        alu_zr;
    logic        alu_ng;

    modport master (
        input  pc_value, imem_ack, instr, jump_target, alu_zr, alu_ng,
        output pc_in, pc_load, pc_inc, imem_addr, imem_req, instr_out, instr_valid
    );

    modport slave (
        output pc_value, imem_ack, instr, jump_target, alu_zr, alu_ng,
        input  pc_in, pc_load, pc_inc, imem_addr, imem_req, instr_out, instr_valid
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/execute controller: owns PC load/inc, the imem request handshake, jump and halt decode.
// Define PC_SEQ_RET_STACK_EN to add a 4-entry CALL/RET return-address stack.
module pc_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter int unsigned ACK_TIMEOUT  = 15
) (
    input  logic           clock,
    input  logic           rst_n,
    input  logic           start,
    pc_sequencer_if.master bus,
    output logic           halted,
    output logic           fault
);

    // state | meaning
    // IDLE  | stopped, waiting for start
    // BOOT  | one-cycle load of RESET_VECTOR into the PC
    // REQ   | fetch outstanding, counting toward ACK_TIMEOUT
    // EXEC  | instruction presented to datapath, PC strobe issued
    // HALT  | halt idiom seen, held until reset
    // FAULT | fetch timeout or stack error, held until reset
    typedef enum logic [2:0] {IDLE, BOOT, REQ, EXEC, HALT, FAULT} state_t;

    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    logic        booted;
    logic [7:0]  to_cnt;
    logic [15:0] instr_q;

    logic        pc_load_c;
    logic        pc_inc_c;
    logic [15:0] pc_in_c;
    logic        req_c;
    logic        valid_c;

    logic        is_c;
    logic        is_norm;
    logic [2:0]  j;
    logic        taken;
    logic        halt_idiom;

    assign is_c  = instr_q[15];
    assign j     = instr_q[2:0];
    assign taken = (j[2] & bus.alu_ng) | (j[1] & bus.alu_zr) | (j[0] & ~bus.alu_ng & ~bus.alu_zr);

`ifdef PC_SEQ_RET_STACK_EN
    logic        is_call;
    logic        is_ret;
    logic        push;
    logic        pop;
    logic [2:0]  depth;
    logic [1:0]  top_idx;
    logic [15:0] stack_top;
    logic [15:0] stack [4];

    assign is_call   = is_c && (instr_q[14:13] == 2'b01);
    assign is_ret    = is_c && (instr_q[14:13] == 2'b10);
    assign is_norm   = is_c && !is_call && !is_ret;
    // depth[1:0]-1 wraps 4 -> 3, so the top entry is correct at full depth too
    assign top_idx   = depth[1:0] - 2'd1;
    assign stack_top = stack[top_idx];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            depth <= '0;
            for (int i = 0; i < 4; i++) begin
                stack[i] <= '0;
            end
        end else if (push) begin
            stack[depth[1:0]] <= bus.pc_value + 16'd1;
            depth             <= depth + 3'd1;
        end else if (pop) begin
            depth <= depth - 3'd1;
        end
    end
`else
    assign is_norm = is_c;
`endif

    assign halt_idiom = is_norm && (j == 3'b111) && (bus.jump_target == bus.pc_value);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            booted  <= 1'b0;
            to_cnt  <= '0;
            instr_q <= '0;
        end else begin
            state <= next_state;
            if (state == BOOT) begin
                booted <= 1'b1;
            end
            if (state == REQ) begin
                if (bus.imem_ack) begin
                    to_cnt  <= '0;
                    instr_q <= bus.instr;
                end else begin
                    to_cnt <= to_cnt + 8'd1;
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        pc_load_c  = 1'b0;
        pc_inc_c   = 1'b0;
        pc_in_c    = '0;
        req_c      = 1'b0;
        valid_c    = 1'b0;
`ifdef PC_SEQ_RET_STACK_EN
        push       = 1'b0;
        pop        = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = booted ? REQ : BOOT;
                end
            end
            BOOT: begin
                pc_load_c  = 1'b1;
                pc_in_c    = RESET_VECTOR;
                next_state = REQ;
            end
            REQ: begin
                req_c = 1'b1;
                if (bus.imem_ack) begin
                    next_state = EXEC;
                end else if (to_cnt == TO_LAST) begin
                    next_state = FAULT;
                end
            end
            EXEC: begin
                valid_c    = 1'b1;
                next_state = start ? REQ : IDLE;
                if (!is_c) begin
                    pc_inc_c = 1'b1;
                end
`ifdef PC_SEQ_RET_STACK_EN
                else if (is_ret) begin
                    if (depth == 3'd0) begin
                        next_state = FAULT;
                    end else begin
                        pc_load_c = 1'b1;
                        pc_in_c   = stack_top;
                        pop       = 1'b1;
                    end
                end else if (is_call) begin
                    if (!taken) begin
                        pc_inc_c = 1'b1;
                    end else if (depth == 3'd4) begin
                        next_state = FAULT;
                    end else begin
                        pc_load_c = 1'b1;
                        pc_in_c   = bus.jump_target;
                        push      = 1'b1;
                    end
                end
`endif
                else if (halt_idiom) begin
                    next_state = HALT;
                end else if (taken) begin
                    pc_load_c = 1'b1;
                    pc_in_c   = bus.jump_target;
                end else begin
                    pc_inc_c = 1'b1;
                end
            end
            HALT:    next_state = HALT;
            FAULT:   next_state = FAULT;
            default: next_state = IDLE;
        endcase
    end

    assign bus.pc_load     = pc_load_c;
    assign bus.pc_inc      = pc_inc_c;
    assign bus.pc_in       = pc_in_c;
    assign bus.imem_req    = req_c;
    assign bus.imem_addr   = bus.pc_value;
    assign bus.instr_out   = instr_q;
    assign bus.instr_valid = valid_c;
    assign halted          = (state == HALT);
    assign fault           = (state == FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: PC model plus small instruction memory, expected EXEC results in a queue.
module tb_pc_sequencer;
    localparam logic [15:0] RV = 16'h0010;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic ack_en = 1'b1;
    logic halted, fault;
    logic [15:0] pc;
    logic [15:0] jt = 16'h0000;
    logic zr = 1'b0, ng = 1'b0;
    logic booted_tb = 1'b0;
    logic [15:0] mem [0:1023];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0, last_exec = 0, gap = 0;
    int req_cnt;

    typedef struct {
        logic [15:0] ins;
        logic        ld;
        logic        inc;
        logic [15:0] pcin;
    } exp_t;
    exp_t sb[$];

    pc_sequencer_if ifc();

    assign ifc.pc_value    = pc;
    assign ifc.imem_ack    = ack_en;
    assign ifc.instr       = mem[pc[9:0]];
    assign ifc.jump_target = jt;
    assign ifc.alu_zr      = zr;
    assign ifc.alu_ng      = ng;

    pc_sequencer #(.RESET_VECTOR(RV), .ACK_TIMEOUT(15)) dut (
        .clock  (clock),
        .rst_n  (rst_n),
        .start  (start),
        .bus    (ifc),
        .halted (halted),
        .fault  (fault)
    );

    always #5 clock = ~clock;

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n)            pc <= 16'hBEEF;
        else if (ifc.pc_load)  pc <= ifc.pc_in;
        else if (ifc.pc_inc)   pc <= pc + 16'd1;
    end

    always @(posedge clock) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (rst_n && ifc.instr_valid) begin
            if (sb.size() == 0) begin
                check("exec_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("instr_out", {16'd0, ifc.instr_out}, {16'd0, e.ins});
                check("pc_load",   {31'd0, ifc.pc_load},   {31'd0, e.ld});
                check("pc_inc",    {31'd0, ifc.pc_inc},    {31'd0, e.inc});
                check("pc_in",     {16'd0, ifc.pc_in},     {16'd0, e.pcin});
                check("one_strobe", {31'd0, ifc.pc_load & ifc.pc_inc}, 32'd0);
            end
            gap       = cyc - last_exec;
            last_exec = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic exp_taken(input logic [2:0] jc, input logic n, input logic z);
        logic lt, eq, gt;
        lt = n;
        eq = z;
        gt = !n && !z;
        return (lt && jc[2]) || (eq && jc[1]) || (gt && jc[0]);
    endfunction

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clock);
        check(tag, sb.size(), 32'd0);
        @(negedge clock);
    endtask

    // Single-step one instruction from IDLE; expected EXEC outcome queued before issue.
    task automatic step(input logic [15:0] ins, input logic [15:0] t, input logic z, input logic n,
                        input logic ld, input logic inc, input logic [15:0] pcin);
        logic [15:0] a;
        a = booted_tb ? pc : RV;
        mem[a[9:0]] = ins;
        jt = t;
        zr = z;
        ng = n;
        sb.push_back('{ins, ld, inc, pcin});
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        booted_tb = 1'b1;
        wait_drain("exec_timeout");
    endtask

    task automatic do_reset();
        @(negedge clock);
        rst_n = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        booted_tb = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;

        @(negedge clock);
        check("rst_halted",   {31'd0, halted}, 32'd0);
        check("rst_fault",    {31'd0, fault}, 32'd0);
        check("rst_load",     {31'd0, ifc.pc_load}, 32'd0);
        check("rst_inc",      {31'd0, ifc.pc_inc}, 32'd0);
        check("rst_req",      {31'd0, ifc.imem_req}, 32'd0);
        check("rst_valid",    {31'd0, ifc.instr_valid}, 32'd0);
        check("rst_instr",    {16'd0, ifc.instr_out}, 32'd0);
        check("rst_pc_in",    {16'd0, ifc.pc_in}, 32'd0);

        // boot then three back-to-back A-instructions, start dropped during the third fetch
        rst_n = 1'b1;
        mem[16'h10] = 16'h0005;
        mem[16'h11] = 16'h0006;
        mem[16'h12] = 16'h0007;
        sb.push_back('{16'h0005, 1'b0, 1'b1, 16'h0000});
        sb.push_back('{16'h0006, 1'b0, 1'b1, 16'h0000});
        sb.push_back('{16'h0007, 1'b0, 1'b1, 16'h0000});
        start = 1'b1;
        @(negedge clock);
        check("boot_load", {31'd0, ifc.pc_load}, 32'd1);
        check("boot_pc_in", {16'd0, ifc.pc_in}, {16'd0, RV});
        check("boot_inc", {31'd0, ifc.pc_inc}, 32'd0);
        check("boot_req", {31'd0, ifc.imem_req}, 32'd0);
        @(negedge clock);
        check("req_after_boot", {31'd0, ifc.imem_req}, 32'd1);
        check("imem_addr_rv", {16'd0, ifc.imem_addr}, {16'd0, RV});
        repeat (4) @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        check("burst_drain", sb.size(), 32'd0);
        check("throughput_gap", gap, 32'd2);
        check("idle_req", {31'd0, ifc.imem_req}, 32'd0);
        check("idle_valid", {31'd0, ifc.instr_valid}, 32'd0);
        check("imem_addr_13", {16'd0, ifc.imem_addr}, 32'h0013);
        booted_tb = 1'b1;

        // JEQ taken / not taken
        step(16'hE302, 16'h0040, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0040);
        step(16'hE302, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        check("pc_after_jeq", {16'd0, pc}, 32'h0041);

        for (int jj = 0; jj < 8; jj++) begin
            for (int f = 0; f < 3; f++) begin
                logic n, z, tk;
                logic [2:0] jc;
                logic [15:0] tgt;
                jc  = 3'(jj);
                n   = (f == 0);
                z   = (f == 1);
                tgt = pc + 16'h0030;
                tk  = exp_taken(jc, n, z);
                step(16'hE300 | {13'd0, jc}, tgt, z, n, tk, !tk, tk ? tgt : 16'h0000);
            end
        end

        // halt idiom at 0x0023
        step(16'hE387, 16'h0023, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0023);
        step(16'hE387, 16'h0023, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("halt_held", {31'd0, halted}, 32'd1);
            check("halt_req", {31'd0, ifc.imem_req}, 32'd0);
            @(negedge clock);
        end
        start = 1'b0;
        do_reset();
        check("halt_cleared", {31'd0, halted}, 32'd0);
        check("reset_idle_req", {31'd0, ifc.imem_req}, 32'd0);

        // withheld ack: fault after 15 REQ cycles
        ack_en = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        req_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (fault) break;
            if (ifc.imem_req) req_cnt++;
        end
        check("timeout_fault", {31'd0, fault}, 32'd1);
        check("timeout_cycles", req_cnt, 32'd15);
        check("timeout_req", {31'd0, ifc.imem_req}, 32'd0);
        do_reset();
        check("fault_cleared", {31'd0, fault}, 32'd0);

        // ack on the 14th REQ cycle
        mem[RV[9:0]] = 16'h0009;
        sb.push_back('{16'h0009, 1'b0, 1'b1, 16'h0000});
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        booted_tb = 1'b1;
        req_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (ifc.imem_req) req_cnt++;
            if (req_cnt == 14) begin
                ack_en = 1'b1;
                break;
            end
        end
        ack_en = 1'b1;
        wait_drain("late_ack_exec");
        check("late_ack_no_fault", {31'd0, fault}, 32'd0);
        check("late_ack_pc", {16'd0, pc}, 32'h0011);

`ifdef PC_SEQ_RET_STACK_EN
        step(16'hE387, 16'h0100, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0100);
        step(16'hA007, 16'h0200, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0200);
        step(16'hC000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0101);
        step(16'hA000, 16'h0500, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            logic [15:0] tgt;
            tgt = 16'h0300 + 16'(i * 16);
            if (i < 4) step(16'hA007, tgt, 1'b0, 1'b0, 1'b1, 1'b0, tgt);
            else       step(16'hA007, tgt, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        end
        check("stack_overflow_fault", {31'd0, fault}, 32'd1);
        check("overflow_req", {31'd0, ifc.imem_req}, 32'd0);
        do_reset();
        step(16'hC000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        check("stack_underflow_fault", {31'd0, fault}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
